// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, resolves JMP
// locally and fills the IF/ID pipeline register for decode.
module instr_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          MEM_DEPTH = 64
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [15:0] Redirect_Addr,
    output logic [15:0] Instr_Addr,
    output logic        Instr_Read,
    input  logic [15:0] Instr_In,
    output logic [15:0] IFID_Instr,
    output logic [15:0] IFID_PC1,
    output logic        IFID_Valid,
    output logic        Halted
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [15:0] END_PC = 16'(MEM_DEPTH);

    state_t      state_r;
    logic [15:0] pc_r;
    logic [15:0] ifid_instr_r;
    logic [15:0] ifid_pc1_r;
    logic        ifid_valid_r;
    logic        read_r;
    logic        halted_r;

    function automatic logic is_jmp(input logic [15:0] word);
        return (word[15:12] == 4'b1111);
    endfunction

    // JMP stays inside the current 4K-word region of the PC.
    function automatic logic [15:0] jmp_target(input logic [15:0] pc, input logic [15:0] word);
        return {pc[15:12], word[11:0]};
    endfunction

    // PC, fetch state and IF/ID register; redirect beats stall, stall beats halt/jump/fetch.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r      <= ST_RUN;
            pc_r         <= RESET_PC;
            ifid_instr_r <= 16'h0000;
            ifid_pc1_r   <= 16'h0000;
            ifid_valid_r <= 1'b0;
            read_r       <= 1'b1;
            halted_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (Redirect) begin
                        pc_r         <= Redirect_Addr;
                        ifid_instr_r <= 16'h0000;
                        ifid_pc1_r   <= 16'h0000;
                        ifid_valid_r <= 1'b0;
                    end else if (Stall) begin
                        pc_r         <= pc_r;
                        ifid_valid_r <= ifid_valid_r;
                    end else if (pc_r >= END_PC) begin
                        state_r      <= ST_HALT;
                        ifid_valid_r <= 1'b0;
                        read_r       <= 1'b0;
                        halted_r     <= 1'b1;
                    end else if (is_jmp(Instr_In)) begin
                        // The jump is consumed here and leaves a bubble behind it.
                        pc_r         <= jmp_target(pc_r, Instr_In);
                        ifid_valid_r <= 1'b0;
                    end else begin
                        ifid_instr_r <= Instr_In;
                        ifid_pc1_r   <= pc_r + 16'd1;
                        ifid_valid_r <= 1'b1;
                        pc_r         <= pc_r + 16'd1;
                    end
                end
                ST_HALT: begin
                    // A late branch from an instruction still in flight restarts fetch.
                    if (Redirect) begin
                        state_r      <= ST_RUN;
                        pc_r         <= Redirect_Addr;
                        ifid_instr_r <= 16'h0000;
                        ifid_pc1_r   <= 16'h0000;
                        ifid_valid_r <= 1'b0;
                        read_r       <= 1'b1;
                        halted_r     <= 1'b0;
                    end else begin
                        pc_r         <= pc_r;
                        ifid_valid_r <= 1'b0;
                        read_r       <= 1'b0;
                        halted_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_HALT;
                    ifid_valid_r <= 1'b0;
                    read_r       <= 1'b0;
                    halted_r     <= 1'b1;
                end
            endcase
        end
    end

    assign Instr_Addr = pc_r;
    assign Instr_Read = read_r;
    assign IFID_Instr = ifid_instr_r;
    assign IFID_PC1   = ifid_pc1_r;
    assign IFID_Valid = ifid_valid_r;
    assign Halted     = halted_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed walk through the fetch scenarios, then random
// stall/redirect/reset traffic against a per-cycle behavioural model.
module tb_instr_fetch;

    localparam int MEM_DEPTH = 64;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [15:0] Redirect_Addr = 16'h0000;
    logic [15:0] Instr_Addr;
    logic        Instr_Read;
    logic [15:0] Instr_In;
    logic [15:0] IFID_Instr;
    logic [15:0] IFID_PC1;
    logic        IFID_Valid;
    logic        Halted;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    // model state
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_pc1 = 16'h0000;
    logic        m_valid = 1'b0;
    logic        m_halt = 1'b0;

    instr_fetch #(.RESET_PC(16'h0000), .MEM_DEPTH(MEM_DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .Redirect(Redirect),
        .Redirect_Addr(Redirect_Addr), .Instr_Addr(Instr_Addr), .Instr_Read(Instr_Read),
        .Instr_In(Instr_In), .IFID_Instr(IFID_Instr), .IFID_PC1(IFID_PC1),
        .IFID_Valid(IFID_Valid), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    assign Instr_In = mem[Instr_Addr];

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, clock the DUT, compare everything.
    task automatic step(input logic rst_n, input logic stall, input logic redir, input logic [15:0] raddr);
        logic [15:0] w;
        Reset_n = rst_n; Stall = stall; Redirect = redir; Redirect_Addr = raddr;
        w = mem[m_pc];
        if (!rst_n) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else if (redir) begin
            m_pc = raddr; m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else if (m_halt) begin
            m_valid = 1'b0;
        end else if (stall) begin
            m_valid = m_valid;
        end else if (int'(m_pc) >= MEM_DEPTH) begin
            m_halt = 1'b1; m_valid = 1'b0;
        end else if (w[15:12] == 4'hF) begin
            m_pc = {m_pc[15:12], w[11:0]}; m_valid = 1'b0;
        end else begin
            m_instr = w; m_pc1 = m_pc + 16'd1; m_valid = 1'b1; m_pc = m_pc + 16'd1;
        end
        @(posedge Clk);
        #1;
        check_val("addr", Instr_Addr, m_pc);
        check_val("read", {15'd0, Instr_Read}, {15'd0, ~m_halt});
        check_val("ifid_instr", IFID_Instr, m_instr);
        check_val("ifid_pc1", IFID_PC1, m_pc1);
        check_val("ifid_valid", {15'd0, IFID_Valid}, {15'd0, m_valid});
        check_val("halted", {15'd0, Halted}, {15'd0, m_halt});
    endtask

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[0] = 16'h8000; mem[1] = 16'h8111; mem[2] = 16'h2012;
        mem[3] = 16'h3003; mem[4] = 16'h4004; mem[5] = 16'h5005; mem[6] = 16'h6006;
        mem[7] = 16'h2133; mem[8] = 16'hE32E; mem[9] = 16'hFFFC;
        for (int i = 60; i < 64; i++) mem[i] = 16'h1200 + 16'(i);

        // reset and free run
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check_val("rst_valid", {15'd0, IFID_Valid}, 16'h0000);
        check_val("rst_pc", Instr_Addr, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check_val("run0", IFID_Instr, 16'h8000);
        check_val("run0_pc1", IFID_PC1, 16'h0001);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check_val("run1", IFID_Instr, 16'h8111);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check_val("run2", IFID_Instr, 16'h2012);
        check_val("run2_pc1", IFID_PC1, 16'h0003);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);

        // stall at PC 5
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0000);
            check_val("stall_addr", Instr_Addr, 16'h0005);
            check_val("stall_instr", IFID_Instr, 16'h4004);
            check_val("stall_pc1", IFID_PC1, 16'h0005);
        end
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check_val("resume", IFID_Instr, 16'h5005);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);

        // redirect beats stall at PC 8
        check_val("pre_redir_pc", Instr_Addr, 16'h0008);
        step(1'b1, 1'b1, 1'b1, 16'h0007);
        check_val("redir_pc", Instr_Addr, 16'h0007);
        check_val("redir_valid", {15'd0, IFID_Valid}, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check_val("redir_instr", IFID_Instr, 16'h2133);
        check_val("redir_pc1", IFID_PC1, 16'h0008);

        // JMP out of range then halt, redirect restarts
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check_val("jmp_pc", Instr_Addr, 16'h0FFC);
        check_val("jmp_valid", {15'd0, IFID_Valid}, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check_val("jmp_halted", {15'd0, Halted}, 16'h0001);
        check_val("jmp_read", {15'd0, Instr_Read}, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 16'h0000);
        check_val("unhalt", {15'd0, Halted}, 16'h0000);
        check_val("unhalt_pc", Instr_Addr, 16'h0000);

        // run off the end of memory
        step(1'b1, 1'b0, 1'b1, 16'd60);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
        check_val("end_halted", {15'd0, Halted}, 16'h0001);
        check_val("end_pc", Instr_Addr, 16'd64);
        for (int i = 0; i < 4; i++) step(1'b1, 1'(i % 2), 1'b0, 16'h0000);
        check_val("end_hold_pc", Instr_Addr, 16'd64);

        // reset wins over redirect and stall
        step(1'b0, 1'b1, 1'b1, 16'h0033);
        check_val("rst_ovr_pc", Instr_Addr, 16'h0000);
        check_val("rst_ovr_halt", {15'd0, Halted}, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check_val("rst_resume", IFID_Instr, 16'h8000);

        // randomized traffic over a freshly randomized memory
        for (int i = 0; i < 128; i++) begin
            r = $urandom;
            if (r[2:0] == 3'd0) mem[i] = {4'hF, 12'($urandom_range(0, 70))};
            else if (r[7:4] == 4'hF) mem[i] = {4'h0, r[19:8]};
            else mem[i] = {r[7:4], r[19:8]};
        end
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, 16'($urandom_range(0, 80)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
